// File: rtl/vga_pixel_scanner_if.sv
// Pixel-scan bus between the scanner (master) and the screen objects (slave).
// The master drives positions, sync and blanking; the slave drives enable.
interface vga_pixel_scanner_if;
   logic        enable;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        pixelEn;
   logic        visible;
   logic        hSync;
   logic        vSync;
   logic        blankN;
   logic        startOfFrame;

   modport master (
      input  enable,
      output pixelX,
      output pixelY,
      output pixelEn,
      output visible,
      output hSync,
      output vSync,
      output blankN,
      output startOfFrame
   );

   modport slave (
      output enable,
      input  pixelX,
      input  pixelY,
      input  pixelEn,
      input  visible,
      input  hSync,
      input  vSync,
      input  blankN,
      input  startOfFrame
   );
endinterface

// File: rtl/vga_pixel_scanner.sv
// VGA raster scanner: divided pixel tick, h/v counters and a sync/blank
// delay line that aligns with the registered pixels the objects return.
module vga_pixel_scanner #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int CLK_DIV    = 2,
   parameter int SYNC_DELAY = 2,
   parameter bit SYNC_POL   = 1'b0
) (
   input logic              clk,
   input logic              resetN,
   vga_pixel_scanner_if.master scan
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_ON   = H_ACTIVE + H_FP;
   localparam int HS_OFF  = HS_ON + H_SYNC;
   localparam int VS_ON   = V_ACTIVE + V_FP;
   localparam int VS_OFF  = VS_ON + V_SYNC;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;
   logic [10:0]   h_cnt;
   logic [10:0]   v_cnt;
   logic          tick;
   logic          h_end;
   logic          v_end;
   logic          vis;
   logic          hs_raw;
   logic          vs_raw;
   logic          sof;
   logic [2:0]    raw;
   logic [2:0]    dly_out;

   assign tick  = scan.enable && (div == DW'(CLK_DIV - 1));
   assign h_end = (h_cnt == 11'(H_TOTAL - 1));
   assign v_end = (v_cnt == 11'(V_TOTAL - 1));

   assign vis = (h_cnt < 11'(H_ACTIVE)) &&
                (v_cnt < 11'(V_ACTIVE));

   assign hs_raw = (h_cnt >= 11'(HS_ON)) &&
                   (h_cnt <  11'(HS_OFF));

   assign vs_raw = (v_cnt >= 11'(VS_ON)) &&
                   (v_cnt <  11'(VS_OFF));

   assign raw = {hs_raw, vs_raw, vis};

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         div <= '0;
      end else if (scan.enable) begin
         if (div == DW'(CLK_DIV - 1))
            div <= '0;
         else
            div <= div + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_end) begin
            h_cnt <= '0;
            if (v_end)
               v_cnt <= '0;
            else
               v_cnt <= v_cnt + 11'd1;
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   // Pulse coincides with the first clk the counters read (0,0).
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         sof <= 1'b0;
      else
         sof <= tick && h_end && v_end;
   end

   generate
      if (SYNC_DELAY == 0) begin : g_pass
         assign dly_out = raw;
      end else begin : g_dly
         logic [2:0] stage [SYNC_DELAY];

         // Stages hold active-high flags; 0 is the inactive reset value.
         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               for (int i = 0; i < SYNC_DELAY; i++)
                  stage[i] <= 3'b000;
            end else if (tick) begin
               stage[0] <= raw;
               for (int i = 1; i < SYNC_DELAY; i++)
                  stage[i] <= stage[i-1];
            end
         end

         assign dly_out = stage[SYNC_DELAY-1];
      end
   endgenerate

   assign scan.pixelX       = h_cnt;
   assign scan.pixelY       = v_cnt;
   assign scan.pixelEn      = tick;
   assign scan.visible      = vis;
   assign scan.hSync        = dly_out[2] ? SYNC_POL : ~SYNC_POL;
   assign scan.vSync        = dly_out[1] ? SYNC_POL : ~SYNC_POL;
   assign scan.blankN       = dly_out[0];
   assign scan.startOfFrame = sof;

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Bench for vga_pixel_scanner on a shrunken raster, checked against
// a tick-count model of position, sync, blanking and frame start.
module tb_vga_pixel_scanner;

   localparam int HA  = 20;
   localparam int HFP = 4;
   localparam int HS  = 6;
   localparam int HBP = 5;
   localparam int VA  = 12;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int CD  = 2;
   localparam int D   = 2;
   localparam bit POL = 1'b0;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FT  = HT * VT;

   logic clk = 1'b0;
   logic resetN;
   int   total = 0;
   int   bad = 0;
   int   ecnt = 0;
   bit   last_inc = 1'b0;

   vga_pixel_scanner_if scan ();

   vga_pixel_scanner #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CLK_DIV(CD), .SYNC_DELAY(D), .SYNC_POL(POL)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .scan(scan)
   );

   always #5 clk = ~clk;

   // Model state: clk edges seen with enable high since reset.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ecnt = 0;
         last_inc = 1'b0;
      end else if (scan.enable) begin
         ecnt++;
         last_inc = 1'b1;
      end else begin
         last_inc = 1'b0;
      end
   end

   function automatic bit hs_at(int t);
      int x;
      x = t % HT;
      return (x >= HA + HFP) && (x < HA + HFP + HS);
   endfunction

   function automatic bit vs_at(int t);
      int y;
      y = (t / HT) % VT;
      return (y >= VA + VFP) && (y < VA + VFP + VS);
   endfunction

   function automatic bit vis_at(int t);
      return ((t % HT) < HA) && (((t / HT) % VT) < VA);
   endfunction

   function automatic logic [27:0] expect_vec();
      int t;
      bit hs_a, vs_a, bl, pen, sof;
      t = ecnt / CD;
      hs_a = 1'b0;
      vs_a = 1'b0;
      bl = 1'b0;
      if (t >= D) begin
         hs_a = hs_at(t - D);
         vs_a = vs_at(t - D);
         bl = vis_at(t - D);
      end
      pen = scan.enable && ((ecnt % CD) == CD - 1);
      sof = last_inc && ecnt > 0 && (ecnt % (CD * FT)) == 0;
      return {11'(t % HT), 11'((t / HT) % VT), pen, vis_at(t),
              hs_a ? POL : !POL, vs_a ? POL : !POL, bl, sof};
   endfunction

   function automatic logic [27:0] observed();
      return {scan.pixelX, scan.pixelY, scan.pixelEn, scan.visible,
              scan.hSync, scan.vSync, scan.blankN, scan.startOfFrame};
   endfunction

   task automatic test_reset();
      logic [27:0] rv;
      rv = {11'd0, 11'd0, 1'b0, 1'b1, !POL, !POL, 1'b0, 1'b0};
      resetN = 1'b0;
      scan.enable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         total++;
         if (observed() !== rv) begin
            bad++;
            $display("FAIL reset obs=%h exp=%h", observed(), rv);
         end
      end
   endtask

   task automatic test_first_ticks();
      @(negedge clk);
      resetN = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (scan.pixelX !== 11'(i / 2) || scan.pixelEn !== 1'(i % 2)) begin
            bad++;
            $display("FAIL first_ticks i=%0d x=%0d en=%b exp x=%0d en=%0d",
                     i, scan.pixelX, scan.pixelEn, i / 2, i % 2);
         end
         total++;
         if (observed() !== expect_vec()) begin
            bad++;
            $display("FAIL first_ticks_vec obs=%h exp=%h", observed(), expect_vec());
         end
      end
   endtask

   task automatic test_line();
      for (int i = 0; i < HT * CD * 3; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (observed() !== expect_vec()) begin
            bad++;
            $display("FAIL line obs=%h exp=%h", observed(), expect_vec());
         end
      end
   endtask

   task automatic test_frame_wrap();
      bit found;
      int n;
      found = 1'b0;
      for (int i = 0; i < 2 * CD * FT + 10; i++) begin
         @(negedge clk);
         #1;
         if (scan.startOfFrame === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found || scan.pixelX !== 11'd0 || scan.pixelY !== 11'd0) begin
         bad++;
         $display("FAIL frame_wrap found=%b x=%0d y=%0d exp 1 0 0",
                  found, scan.pixelX, scan.pixelY);
      end
      n = 0;
      found = 1'b0;
      for (int i = 0; i < CD * FT + 10; i++) begin
         @(negedge clk);
         #1;
         n++;
         total++;
         if (observed() !== expect_vec()) begin
            bad++;
            $display("FAIL frame_vec obs=%h exp=%h", observed(), expect_vec());
         end
         if (scan.startOfFrame === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found || n != CD * FT) begin
         bad++;
         $display("FAIL frame_period got=%0d exp=%0d", n, CD * FT);
      end
   endtask

   task automatic test_pause();
      logic [27:0] held;
      bit found;
      found = 1'b0;
      for (int i = 0; i < CD * FT + 10; i++) begin
         @(negedge clk);
         #1;
         if (scan.pixelX === 11'd10) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL pause_wait x=%0d exp=10", scan.pixelX);
      end
      scan.enable = 1'b0;
      #1;
      held = observed();
      repeat (50) begin
         @(negedge clk);
         #1;
         total++;
         if (observed() !== held || scan.pixelX !== 11'd10 || scan.pixelEn !== 1'b0) begin
            bad++;
            $display("FAIL pause_hold obs=%h exp=%h", observed(), held);
         end
         total++;
         if (observed() !== expect_vec()) begin
            bad++;
            $display("FAIL pause_vec obs=%h exp=%h", observed(), expect_vec());
         end
      end
      scan.enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 4 * CD; i++) begin
         @(negedge clk);
         #1;
         if (scan.pixelX !== 11'd10) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found || scan.pixelX !== 11'd11) begin
         bad++;
         $display("FAIL pause_resume x=%0d exp=11", scan.pixelX);
      end
   endtask

   task automatic test_random_enable();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         scan.enable = ($urandom_range(0, 9) < 8);
         #1;
         total++;
         if (observed() !== expect_vec()) begin
            bad++;
            $display("FAIL rand_en obs=%h exp=%h", observed(), expect_vec());
         end
      end
      scan.enable = 1'b1;
   endtask

   task automatic test_async_reset();
      logic [27:0] rv;
      bit found;
      rv = {11'd0, 11'd0, 1'b0, 1'b1, !POL, !POL, 1'b0, 1'b0};
      found = 1'b0;
      for (int i = 0; i < CD * FT + 10; i++) begin
         @(negedge clk);
         #1;
         if (scan.pixelX === 11'd15 && scan.pixelY === 11'd5) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL areset_wait x=%0d y=%0d exp 15 5", scan.pixelX, scan.pixelY);
      end
      @(negedge clk);
      #3;
      resetN = 1'b0;
      #1;
      total++;
      if (observed() !== rv) begin
         bad++;
         $display("FAIL areset_now obs=%h exp=%h", observed(), rv);
      end
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (observed() !== expect_vec() || scan.startOfFrame !== 1'b0) begin
            bad++;
            $display("FAIL areset_run obs=%h exp=%h", observed(), expect_vec());
         end
      end
   endtask

   initial begin
      resetN = 1'b0;
      scan.enable = 1'b1;
      test_reset();
      test_first_ticks();
      test_line();
      test_frame_wrap();
      test_pause();
      test_random_enable();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
